serdiv_arbiter: RTL
===================

// Module: serdiv_arbiter
// PURPOSE
//  Shares one serdiv serial divider between NREQ independent requesters (e.g. per-issue-port
//  mult/div units). Round-robin grant, one operation in flight, result routed back to the owner.
//  Per-requester flush kills an in-flight op by pulsing the divider flush.
//  Sits between the requesting functional units and a single serdiv instance.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  WIDTH  64  operand/result width, must match serdiv WIDTH
//  ID_W   3   transaction id width, passed through unchanged
// PORTS
//  clk_i         in   1            clock
//  rst_ni        in   1            asynchronous reset, active low
//  req_vld_i     in   NREQ         request valid per requester
//  req_rdy_o     out  NREQ         request accepted (one-hot or zero)
//  req_id_i      in   NREQ*ID_W    per-requester transaction id
//  req_op_a_i    in   NREQ*WIDTH   dividend
//  req_op_b_i    in   NREQ*WIDTH   divisor
//  req_opcode_i  in   NREQ*2       00 divu, 01 div, 10 remu, 11 rem
//  flush_i       in   NREQ         per-requester flush
//  rsp_vld_o     out  NREQ         result valid, owner bit only
//  rsp_rdy_i     in   NREQ         result ready per requester
//  rsp_id_o      out  ID_W         id of returned result (shared bus)
//  rsp_res_o     out  WIDTH        result (shared bus)
//  div_in_vld_o/div_in_rdy_i/div_id_o/div_op_a_o/div_op_b_o/div_opcode_o  divider issue side
//  div_out_vld_i/div_out_rdy_o/div_id_i/div_res_i                          divider result side
//  div_flush_o   out  1            divider flush
//  owner_o       out  clog2(NREQ)  current owner index, valid while busy_o
//  busy_o        out  1            operation in flight
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_q=0, owner_q=0.
//  - FSM IDLE -> BUSY -> IDLE.
//  - IDLE:
//    - cand = req_vld_i & ~flush_i.
//    - Grant g = first set bit of cand searching from rr_q upward, wrapping at NREQ.
//    - div_in_vld_o = |cand. Divider operands/id/opcode are muxed from g.
//    - req_rdy_o[g] = div_in_rdy_i. Issue is combinational; no extra latency.
//    - On div_in_vld_o & div_in_rdy_i: owner_q<=g, go BUSY.
//  - BUSY:
//    - req_rdy_o=0, div_in_vld_o=0.
//    - rsp_vld_o[owner_q]=div_out_vld_i. rsp_id_o/rsp_res_o = div_id_i/div_res_i, combinational.
//    - div_out_rdy_o = rsp_rdy_i[owner_q].
//    - On the out handshake: rr_q<=owner_q+1 (wrap), go IDLE. The next grant is possible the following cycle.
//  - Backpressure: while rsp_rdy_i[owner_q]=0 the result is held by serdiv and outputs stay stable.
//  - Flush of the owner in BUSY: div_flush_o=1 for that cycle; rsp_vld_o forced 0 (dropped even if
//    div_out_vld_i=1 the same cycle); rr_q<=owner_q+1; go IDLE.
//  - Flush of a non-owner: masks only that requester's candidate bit; no divider flush.
//  - Flush in IDLE of the would-be grantee: it is masked and the next candidate is granted the same cycle.
//  - Reset mid-operation: immediate return to reset state; the divider is reset by the shared rst_ni.
//  - Operand and result arithmetic is entirely in serdiv; this block does no width conversion.
// TESTING
//  - Req0 only, a=100 b=7 opcode=00 id=5 -> one serdiv op; rsp_vld_o=0001, res=14, id=5; then idle.
//  - All 4 requesters valid continuously from reset, rsp_rdy_i=1111 -> grant order 0,1,2,3,0.
//  - Req1 rem a=-17 b=5, rsp_rdy_i[1]=0 for 10 cycles -> res=-2 held stable; req_rdy_o=0 throughout;
//    releases on ready.
//  - Req2 in flight, flush_i[2] pulse mid-op -> div_flush_o 1 cycle, no rsp_vld_o; pending req3 granted
//    the next cycle.
//  - flush_i[owner] in the same cycle as div_out_vld_i -> response dropped; rr_q advanced past the owner.
//  - rst_ni low during BUSY -> all outputs 0 asynchronously; after release req0 is granted first.

Source files
------------

// File: rtl/serdiv_arbiter_if.sv
// serdiv_arbiter_if: requester-side and divider-side signals of the serdiv arbiter
interface serdiv_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int ID_W  = 3
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]       req_vld_i;
  logic [NREQ-1:0]       req_rdy_o;
  logic [NREQ*ID_W-1:0]  req_id_i;
  logic [NREQ*WIDTH-1:0] req_op_a_i;
  logic [NREQ*WIDTH-1:0] req_op_b_i;
  logic [NREQ*2-1:0]     req_opcode_i;
  logic [NREQ-1:0]       flush_i;
  logic [NREQ-1:0]       rsp_vld_o;
  logic [NREQ-1:0]       rsp_rdy_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [WIDTH-1:0]      rsp_res_o;
  logic                  div_in_vld_o;
  logic                  div_in_rdy_i;
  logic [ID_W-1:0]       div_id_o;
  logic [WIDTH-1:0]      div_op_a_o;
  logic [WIDTH-1:0]      div_op_b_o;
  logic [1:0]            div_opcode_o;
  logic                  div_out_vld_i;
  logic                  div_out_rdy_o;
  logic [ID_W-1:0]       div_id_i;
  logic [WIDTH-1:0]      div_res_i;
  logic                  div_flush_o;
  logic [IW-1:0]         owner_o;
  logic                  busy_o;
  modport slave (
    input  req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i, flush_i, rsp_rdy_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i,
    output req_rdy_o, rsp_vld_o, rsp_id_o, rsp_res_o, div_in_vld_o, div_id_o, div_op_a_o,
           div_op_b_o, div_opcode_o, div_out_rdy_o, div_flush_o, owner_o, busy_o
  );
  modport master (
    output req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i, flush_i, rsp_rdy_i,
           div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i,
    input  req_rdy_o, rsp_vld_o, rsp_id_o, rsp_res_o, div_in_vld_o, div_id_o, div_op_a_o,
           div_op_b_o, div_opcode_o, div_out_rdy_o, div_flush_o, owner_o, busy_o
  );
endinterface

// File: rtl/serdiv_arbiter.sv
// serdiv_arbiter: round-robin sharing of one serdiv divider between NREQ requesters,
// one operation in flight, result routed back to its owner, owner flush kills the op.
module serdiv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int ID_W  = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  serdiv_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic {IDLE, BUSY} state_e;
  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, owner_q, owner_d, grant, idx, rr_nxt;
  logic [NREQ-1:0] cand;
  logic            found, own_flush;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end
  // first candidate at or above rr_q, wrapping at NREQ
  always_comb begin
    cand  = bus.req_vld_i & ~bus.flush_i;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NREQ);
      if (!found && cand[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  // outputs are gated by rst_ni so they read zero for the whole reset window
  always_comb begin
    own_flush         = bus.flush_i[owner_q];
    rr_nxt            = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    state_d           = state_q;
    rr_d              = rr_q;
    owner_d           = owner_q;
    bus.req_rdy_o     = '0;
    bus.rsp_vld_o     = '0;
    bus.rsp_id_o      = '0;
    bus.rsp_res_o     = '0;
    bus.div_in_vld_o  = 1'b0;
    bus.div_id_o      = '0;
    bus.div_op_a_o    = '0;
    bus.div_op_b_o    = '0;
    bus.div_opcode_o  = '0;
    bus.div_out_rdy_o = 1'b0;
    bus.div_flush_o   = 1'b0;
    if (rst_ni && state_q == IDLE) begin
      bus.div_in_vld_o     = found;
      bus.req_rdy_o[grant] = found & bus.div_in_rdy_i;
      for (int i = 0; i < NREQ; i++) begin
        if (grant == IW'(i)) begin
          bus.div_id_o     = bus.req_id_i[i*ID_W +: ID_W];
          bus.div_op_a_o   = bus.req_op_a_i[i*WIDTH +: WIDTH];
          bus.div_op_b_o   = bus.req_op_b_i[i*WIDTH +: WIDTH];
          bus.div_opcode_o = bus.req_opcode_i[i*2 +: 2];
        end
      end
      if (found && bus.div_in_rdy_i) begin
        owner_d = grant;
        state_d = BUSY;
      end
    end else if (rst_ni) begin
      bus.rsp_vld_o[owner_q] = bus.div_out_vld_i & ~own_flush;
      bus.rsp_id_o           = bus.div_id_i;
      bus.rsp_res_o          = bus.div_res_i;
      bus.div_out_rdy_o      = bus.rsp_rdy_i[owner_q] & ~own_flush;
      bus.div_flush_o        = own_flush;
      if (own_flush || (bus.div_out_vld_i && bus.rsp_rdy_i[owner_q])) begin
        rr_d    = rr_nxt;
        state_d = IDLE;
      end
    end
  end
  assign bus.busy_o  = (state_q == BUSY);
  assign bus.owner_o = owner_q;
endmodule
